// File: rtl/cache_refill_ctrl_pkg.sv
// Shared types and sizes for the cache line refill controller.
// Exports: refill_state_t, refill_req_t, geometry params, way_onehot().
package cache_types;

    localparam int ADDR_W   = 32;
    localparam int TAG_W    = 23;
    localparam int SET_W    = 4;
    localparam int OFFSET_W = 5;
    localparam int LINE_W   = 256;
    localparam int WAYS     = 4;
    localparam int WAY_W    = 2;
    localparam int VTAG_W   = TAG_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        RD,
        FILL,
        DONE
    } refill_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WAY_W-1:0]  way;
        logic              valid;
        logic [VTAG_W-1:0] tag;
        logic [LINE_W-1:0] data;
    } refill_req_t;

    function automatic logic [WAYS-1:0] way_onehot(input logic [WAY_W-1:0] w);
        logic [WAYS-1:0] oh;
        oh    = '0;
        oh[w] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss refill controller: optional dirty write-back, line read, array fill.
// Ports: clk/rst (sync, active-high); miss_* and victim_* request inputs;
// dfp_* memory port (read/write/resp); arr_* array write; refill_done; busy.
module cache_refill_ctrl
    import cache_types::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_req,
    input  logic [ADDR_W-1:0]   miss_addr,
    input  logic [WAY_W-1:0]    victim_way,
    input  logic                victim_valid,
    input  logic [VTAG_W-1:0]   victim_tag,
    input  logic [LINE_W-1:0]   victim_data,
    output logic [ADDR_W-1:0]   dfp_addr,
    output logic                dfp_read,
    output logic                dfp_write,
    output logic [LINE_W-1:0]   dfp_wdata,
    input  logic [LINE_W-1:0]   dfp_rdata,
    input  logic                dfp_resp,
    output logic [WAYS-1:0]     arr_we,
    output logic [SET_W-1:0]    arr_set,
    output logic [VTAG_W-1:0]   arr_tag,
    output logic [LINE_W-1:0]   arr_data,
    output logic                arr_valid,
    output logic                refill_done,
    output logic                busy
);

    refill_state_t     state;
    refill_state_t     state_next;
    refill_req_t       req;
    logic [LINE_W-1:0] line;

    logic [SET_W-1:0]  req_set;
    logic [TAG_W-1:0]  req_tag;
    logic              victim_dirty;

    assign req_set      = req.addr[OFFSET_W +: SET_W];
    assign req_tag      = req.addr[ADDR_W-1 -: TAG_W];
    assign victim_dirty = victim_valid & victim_tag[VTAG_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            req   <= '0;
            line  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && miss_req) begin
                req.addr  <= miss_addr;
                req.way   <= victim_way;
                req.valid <= victim_valid;
                req.tag   <= victim_tag;
                req.data  <= victim_data;
            end
            if (state == RD && dfp_resp) begin
                line <= dfp_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (miss_req) begin
                    state_next = victim_dirty ? WB : RD;
                end
            end
            WB:      if (dfp_resp) state_next = RD;
            RD:      if (dfp_resp) state_next = FILL;
            FILL:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced low while rst is high, even before the
    // state register has been cleared by the first reset edge.
    always_comb begin
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        arr_we      = '0;
        arr_set     = '0;
        arr_tag     = '0;
        arr_data    = '0;
        arr_valid   = 1'b0;
        refill_done = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            unique case (state)
                WB: begin
                    dfp_write = 1'b1;
                    dfp_addr  = {req.tag[TAG_W-1:0], req_set,
                                 {OFFSET_W{1'b0}}};
                    dfp_wdata = req.data;
                end
                RD: begin
                    dfp_read = 1'b1;
                    dfp_addr = {req.addr[ADDR_W-1:OFFSET_W],
                                {OFFSET_W{1'b0}}};
                end
                FILL: begin
                    arr_we    = way_onehot(req.way);
                    arr_set   = req_set;
                    arr_tag   = {1'b0, req_tag};
                    arr_data  = line;
                    arr_valid = 1'b1;
                end
                DONE:    refill_done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: expected fills queued at miss,
// popped and compared when the array write appears.
module tb_cache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic [1:0]   victim_way = '0;
    logic         victim_valid = 1'b0;
    logic [23:0]  victim_tag = '0;
    logic [255:0] victim_data = '0;
    logic [255:0] dfp_rdata = '0;
    logic         dfp_resp = 1'b0;

    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [3:0]   arr_we;
    logic [3:0]   arr_set;
    logic [23:0]  arr_tag;
    logic [255:0] arr_data;
    logic         arr_valid;
    logic         refill_done;
    logic         busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0]  wb_addr;
        logic [255:0] wb_data;
        logic [31:0]  rd_addr;
        logic [3:0]   we;
        logic [3:0]   set;
        logic [23:0]  tag;
        logic [255:0] data;
    } exp_t;

    exp_t q[$];

    cache_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .victim_way   (victim_way),
        .victim_valid (victim_valid),
        .victim_tag   (victim_tag),
        .victim_data  (victim_data),
        .dfp_addr     (dfp_addr),
        .dfp_read     (dfp_read),
        .dfp_write    (dfp_write),
        .dfp_wdata    (dfp_wdata),
        .dfp_rdata    (dfp_rdata),
        .dfp_resp     (dfp_resp),
        .arr_we       (arr_we),
        .arr_set      (arr_set),
        .arr_tag      (arr_tag),
        .arr_data     (arr_data),
        .arr_valid    (arr_valid),
        .refill_done  (refill_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    task automatic check_all_low(input string tag);
        check({tag, "_rd"},   dfp_read, 0);
        check({tag, "_wr"},   dfp_write, 0);
        check({tag, "_addr"}, dfp_addr, 0);
        check({tag, "_we"},   arr_we, 0);
        check({tag, "_av"},   arr_valid, 0);
        check({tag, "_done"}, refill_done, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_miss(input logic [31:0] a, input logic [1:0] w,
                            input logic v, input logic [23:0] vt,
                            input logic [255:0] vd, input int wb_dly,
                            input int rd_dly, input logic [255:0] rdata,
                            input bit hold);
        exp_t e;
        bit   dirty;
        int   cyc, wbc, rdc, done_cyc, exp_done;
        dirty     = v && vt[23];
        e.wb_addr = {vt[22:0], a[8:5], 5'b0};
        e.wb_data = vd;
        e.rd_addr = {a[31:5], 5'b0};
        e.we      = 4'b0001 << w;
        e.set     = a[8:5];
        e.tag     = {1'b0, a[31:9]};
        e.data    = rdata;
        q.push_back(e);

        miss_addr    = a;
        victim_way   = w;
        victim_valid = v;
        victim_tag   = vt;
        victim_data  = vd;
        miss_req     = 1'b1;
        tick();
        if (hold) begin
            // junk while busy: any re-latch would corrupt later checks
            miss_addr   = a ^ 32'hFFFF_FFE0;
            victim_way  = w + 2'd1;
            victim_tag  = vt ^ 24'h7F_FFFF;
            victim_data = ~vd;
        end else begin
            miss_req = 1'b0;
        end

        exp_done = (dirty ? wb_dly + 1 : 0) + rd_dly + 3;
        cyc      = 1;
        wbc      = 0;
        rdc      = 0;
        done_cyc = 0;
        while (done_cyc == 0 && cyc < 200) begin
            dfp_resp = 1'b0;
            check("rw_excl", dfp_read & dfp_write, 0);
            check("busy", busy, 1);
            if (dfp_write) begin
                check("wb_expected", dirty, 1);
                check("wb_addr", dfp_addr, e.wb_addr);
                check("wb_data", dfp_wdata, e.wb_data);
                if (wbc == wb_dly) dfp_resp = 1'b1;
                wbc++;
            end
            if (dfp_read) begin
                check("rd_after_wb", wbc, dirty ? wb_dly + 1 : 0);
                check("rd_addr", dfp_addr, e.rd_addr);
                if (rdc == rd_dly) begin
                    dfp_resp  = 1'b1;
                    dfp_rdata = rdata;
                end else begin
                    dfp_rdata = ~rdata;
                end
                rdc++;
            end
            if (arr_we != 4'b0000) begin
                check("fill_cyc", cyc, exp_done - 1);
                if (q.size() == 0) begin
                    check("sb_empty", 0, 1);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    check("arr_we", arr_we, x.we);
                    check("arr_set", arr_set, x.set);
                    check("arr_tag", arr_tag, x.tag);
                    check("arr_data", arr_data, x.data);
                    check("arr_valid", arr_valid, 1);
                end
            end
            if (refill_done) done_cyc = cyc;
            tick();
            cyc++;
        end
        dfp_resp = 1'b0;
        check("done_cyc", done_cyc, exp_done);
        check("rd_cycles", rdc, rd_dly + 1);
        check("idle_busy", busy, 0);
        check("idle_we", arr_we, 0);
    endtask

    initial begin
        logic [255:0] l0;
        logic [255:0] l1;
        int           n;

        rst = 1'b1;
        miss_req = 1'b1;
        tick();
        tick();
        check_all_low("rst");
        check("rst_wdata", dfp_wdata, 0);
        check("rst_adata", arr_data, 0);
        check("rst_atag", arr_tag, 0);
        check("rst_aset", arr_set, 0);
        miss_req = 1'b0;
        rst = 1'b0;
        tick();
        check_all_low("post_rst");

        // clean miss, memory answers in first RD cycle
        run_miss(32'h0000_1234, 2'd1, 1'b0, 24'h0, rand_line(),
                 0, 0, rand_line(), 1'b0);

        // dirty victim, write-back answered after 4 cycles
        run_miss({23'h5A5A5, 4'd2, 5'd11}, 2'd3, 1'b1, 24'h80_00AB,
                 rand_line(), 4, 1, rand_line(), 1'b0);

        // valid but clean victim, read withheld 10 cycles
        run_miss(32'hCAFE_F00D, 2'd2, 1'b1, 24'h00_1234, rand_line(),
                 0, 10, rand_line(), 1'b0);

        // reset pulse in second RD cycle
        miss_addr    = 32'h0000_2040;
        victim_valid = 1'b0;
        miss_req     = 1'b1;
        tick();
        miss_req = 1'b0;
        check("mrd_rd1", dfp_read, 1);
        tick();
        check("mrd_rd2", dfp_read, 1);
        rst = 1'b1;
        #1;
        check_all_low("mrd_rst_hi");
        tick();
        rst = 1'b0;
        #1;
        check_all_low("mrd_after");
        dfp_resp = 1'b1;
        tick();
        dfp_resp = 1'b0;
        check_all_low("mrd_idle");

        // back-to-back with miss_req held through the first refill
        l0 = rand_line();
        l1 = rand_line();
        run_miss(32'h1357_9BDF, 2'd0, 1'b1, 24'h80_4321, l0,
                 2, 3, l1, 1'b1);
        run_miss(32'h2468_ACE0, 2'd2, 1'b0, 24'h0, l1,
                 0, 0, l0, 1'b0);

        // stray response while idle
        dfp_resp = 1'b1;
        tick();
        tick();
        dfp_resp = 1'b0;
        check_all_low("stray");

        // dirty victim, write-back answered immediately
        run_miss(32'hFFFF_FFFF, 2'd0, 1'b1, 24'hFF_FFFF, rand_line(),
                 0, 0, rand_line(), 1'b0);

        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(0, 1);
            run_miss($urandom(), 2'($urandom_range(0, 3)), 1'(n),
                     24'($urandom()), rand_line(),
                     $urandom_range(0, 5), $urandom_range(0, 5),
                     rand_line(), 1'b0);
        end

        check("sb_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
